// File: rtl/read_dispatch_pkg.sv
// Shared definitions for read_dispatch_scheduler: the instruction layout,
// the slot record, the slot extraction helper and the FSM state encoding.
package read_dispatch_pkg;

    localparam int NUM_SLOTS = 20;
    localparam int SLOT_W    = 24;
    localparam int SLOT0_MSB = 509;
    localparam int READ_MSB  = 511;
    localparam int READ_LSB  = 200;
    localparam int TAG_W     = 13;
    localparam int LSB_W     = 11;
    localparam int IDX_W     = 5;

    // One minimizer slot: tag in the upper bits, minimizer LSB field below it.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [LSB_W-1:0] lsb;
    } slot_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Slot k occupies inst[509-24k : 486-24k]; indices past the last slot read as empty.
    function automatic slot_t get_slot(input logic [READ_MSB:0] w, input logic [IDX_W-1:0] k);
        logic [8:0] base;
        base = 9'(SLOT0_MSB - SLOT_W + 1) - (9'(k) * 9'(SLOT_W));
        if (k >= IDX_W'(NUM_SLOTS)) begin
            return '0;
        end
        return slot_t'(w[base +: SLOT_W]);
    endfunction

endpackage

// File: rtl/read_dispatch_scheduler_slot_priority_picker.sv
// slot_priority_picker: finds the lowest-index set bit of a slot mask.
// Shared by the capture path and the slot-advance path of the scheduler.
module slot_priority_picker
    import read_dispatch_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] mask,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (mask[k]) begin
                found = 1'b1;
                idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/read_dispatch_scheduler.sv
// read_dispatch_scheduler: accepts one 512-bit instruction, decodes its 20
// minimizer slots and issues every valid slot, in ascending slot order, to
// the addressed bank. Keeps saturating dispatch and drop counters.
// Optional feature macro: DISPATCH_DEDUP_EN (keep only the first valid slot
// per bank at capture; later duplicates vanish without counting as drops).
module read_dispatch_scheduler
    import read_dispatch_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int WIDTH_LSB = 10,
    parameter int WIDTH_MSB = 12,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inst_valid,
    output logic                         inst_ready,
    input  logic [READ_MSB:0]            inst,
    output logic [NUM_BANKS-1:0]         disp_valid,
    input  logic [NUM_BANKS-1:0]         disp_ready,
    output logic [WIDTH_LSB:0]           disp_minimizer,
    output logic [READ_MSB-READ_LSB:0]   disp_read,
    output logic [IDX_W-1:0]             disp_slot,
    output logic                         busy,
    output logic                         inst_done,
    output logic [CNT_W-1:0]             disp_count,
    output logic [CNT_W-1:0]             drop_count
);

    localparam int BANK_W = $clog2(NUM_BANKS);

    // Handshakes: the upstream instruction transfers on inst_valid & inst_ready;
    // a dispatch transfers on disp_valid[b] & disp_ready[b] for the one-hot bank b.
    // Once disp_valid is up, it and its payload hold until that transfer.

    state_t                 state_q, state_d;
    logic [READ_MSB:0]      inst_q;
    logic [NUM_SLOTS-1:0]   pending_q;
    logic [NUM_SLOTS-1:0]   cap_mask;
    logic [NUM_SLOTS-1:0]   nxt_mask;
    logic [IDX_W-1:0]       drop_num;
    logic                   cap_found, nxt_found;
    logic [IDX_W-1:0]       cap_idx, nxt_idx;
    logic                   rdy_q;
    logic                   done_q;
    logic [NUM_BANKS-1:0]   valid_q;
    logic [WIDTH_LSB:0]     min_q;
    logic [IDX_W-1:0]       slot_q;
    logic [CNT_W-1:0]       disp_cnt_q, drop_cnt_q;
    logic [CNT_W:0]         drop_sum;
    logic                   accept, hs, load;
    logic [READ_MSB:0]      sel_word;
    logic [IDX_W-1:0]       sel_idx;
    slot_t                  sel_slot;
    logic [BANK_W-1:0]      sel_bank;

    assign accept   = (state_q == IDLE) && inst_valid && rdy_q;
    assign hs       = (state_q == ISSUE) && |(valid_q & disp_ready);
    assign nxt_mask = pending_q & ~(NUM_SLOTS'(1) << slot_q);
    assign load     = (accept && cap_found) || (hs && nxt_found);

    // Decode the incoming instruction into a pending mask and a drop tally.
    always_comb begin
        slot_t s;
`ifdef DISPATCH_DEDUP_EN
        logic [NUM_BANKS-1:0] seen;
        seen = '0;
`endif
        cap_mask = '0;
        drop_num = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            s = get_slot(inst, IDX_W'(k));
            if (s.tag[WIDTH_MSB]) begin
                if ((s.tag[WIDTH_MSB-1:0] >> BANK_W) == '0) begin
`ifdef DISPATCH_DEDUP_EN
                    if (!seen[s.tag[BANK_W-1:0]]) begin
                        cap_mask[k]              = 1'b1;
                        seen[s.tag[BANK_W-1:0]]  = 1'b1;
                    end
`else
                    cap_mask[k] = 1'b1;
`endif
                end else begin
                    drop_num = drop_num + IDX_W'(1);
                end
            end
        end
    end

    slot_priority_picker u_cap_pick (
        .mask  (cap_mask),
        .found (cap_found),
        .idx   (cap_idx)
    );

    slot_priority_picker u_nxt_pick (
        .mask  (nxt_mask),
        .found (nxt_found),
        .idx   (nxt_idx)
    );

    // Capture reads the live instruction; advancing reads the held copy.
    assign sel_word = (state_q == IDLE) ? inst : inst_q;
    assign sel_idx  = (state_q == IDLE) ? cap_idx : nxt_idx;
    assign sel_slot = get_slot(sel_word, sel_idx);
    assign sel_bank = sel_slot.tag[BANK_W-1:0];
    assign drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_num);

    // Next-state logic: IDLE -> ISSUE on a capture with work, back on the last handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && cap_found) state_d = ISSUE;
            ISSUE:   if (hs && !nxt_found)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Instruction hold, pending mask and the dispatch payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q    <= '0;
            pending_q <= '0;
            valid_q   <= '0;
            min_q     <= '0;
            slot_q    <= '0;
        end else begin
            if (accept) begin
                inst_q    <= inst;
                pending_q <= cap_mask;
            end else if (hs) begin
                pending_q <= nxt_mask;
            end
            if (load) begin
                valid_q <= NUM_BANKS'(1) << sel_bank;
                min_q   <= sel_slot.lsb[WIDTH_LSB:0];
                slot_q  <= sel_idx;
            end else if (hs) begin
                valid_q <= '0;
            end
        end
    end

    // Ready follows the state we land in; done pulses as an instruction retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rdy_q  <= (state_d == IDLE);
            done_q <= (accept && !cap_found) || (hs && !nxt_found);
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (hs && (disp_cnt_q != '1)) disp_cnt_q <= disp_cnt_q + CNT_W'(1);
            if (accept) drop_cnt_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    assign inst_ready     = rdy_q;
    assign disp_valid     = valid_q;
    assign disp_minimizer = min_q;
    assign disp_read      = inst_q[READ_MSB:READ_LSB];
    assign disp_slot      = slot_q;
    assign busy           = (state_q == ISSUE);
    assign inst_done      = done_q;
    assign disp_count     = disp_cnt_q;
    assign drop_count     = drop_cnt_q;

endmodule

// File: tb/tb_read_dispatch_scheduler.sv
// Directed bench for read_dispatch_scheduler (NUM_BANKS = 4, 8-bit counters
// so saturation is reachable quickly). Works with or without DISPATCH_DEDUP_EN.
module tb_read_dispatch_scheduler;

    localparam int NB  = 4;
    localparam int CW  = 8;
    localparam int MAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             inst_valid = 1'b0;
    logic             inst_ready;
    logic [511:0]     inst = '0;
    logic [NB-1:0]    disp_valid;
    logic [NB-1:0]    disp_ready = '0;
    logic [10:0]      disp_minimizer;
    logic [311:0]     disp_read;
    logic [4:0]       disp_slot;
    logic             busy;
    logic             inst_done;
    logic [CW-1:0]    disp_count;
    logic [CW-1:0]    drop_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_disp = 0;
    int exp_drop = 0;

    // Expected dispatches in order: {one-hot bank, slot index, minimizer}.
    logic [19:0] exp_q[$];

    read_dispatch_scheduler #(
        .NUM_BANKS (NB),
        .WIDTH_LSB (10),
        .WIDTH_MSB (12),
        .CNT_W     (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_minimizer (disp_minimizer),
        .disp_read      (disp_read),
        .disp_slot      (disp_slot),
        .busy           (busy),
        .inst_done      (inst_done),
        .disp_count     (disp_count),
        .drop_count     (drop_count)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [511:0] put_slot(input logic [511:0] w, input int k,
                                              input logic [12:0] tag, input logic [10:0] lsb);
        logic [511:0] r;
        r = w;
        r[486 - 24 * k +: 24] = {tag, lsb};
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > MAX) ? MAX : v;
    endfunction

    task automatic push_exp(input int bank, input int slot, input logic [10:0] lsb);
        logic [3:0] oh;
        oh = 4'(1 << bank);
        exp_q.push_back({oh, 5'(slot), lsb});
        exp_disp = sat(exp_disp + 1);
    endtask

    // Present one instruction; returns just after its accept edge.
    task automatic send_inst(input logic [511:0] w);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!inst_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 1'b0, 1'b1);
        inst       = w;
        inst_valid = 1'b1;
        @(posedge clk);
        #1 inst_valid = 1'b0;
    endtask

    // With all banks ready, expect the queued dispatches back to back, then done.
    task automatic drain();
        int n;
        logic [19:0] e;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check("dispatch", {disp_valid, disp_slot, disp_minimizer}, e);
        end
        @(negedge clk);
        check("inst_done", inst_done, 1'b1);
        check("disp_count", disp_count, exp_disp);
        check("drop_count", drop_count, exp_drop);
    endtask

    initial begin
        logic [511:0] w;
        logic [10:0]  l0, l1, l2, l3;

        // Reset state.
        @(negedge clk);
        check("rst_inst_ready", inst_ready, 1'b0);
        check("rst_disp_valid", disp_valid, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_disp_count", disp_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", inst_ready, 1'b1);
        check("done_after_rst", inst_done, 1'b0);
        disp_ready = 4'hF;

        // Single slot 3 to bank 2.
        w = '0;
        w[511:510] = 2'b11;
        w[29:0]    = 30'($urandom);
        w = put_slot(w, 3, 13'h1002, 11'h2A5);
        send_inst(w);
        @(negedge clk);
        check("t1_valid", disp_valid, 4'b0100);
        check("t1_min", disp_minimizer, 11'h2A5);
        check("t1_slot", disp_slot, 5'd3);
        check("t1_read", disp_read, w[511:200]);
        check("t1_busy", busy, 1'b1);
        check("t1_ready_low", inst_ready, 1'b0);
        @(negedge clk);
        check("t1_done", inst_done, 1'b1);
        check("t1_ready_back", inst_ready, 1'b1);
        check("t1_valid_off", disp_valid, 4'b0000);
        check("t1_count", disp_count, 1);
        exp_disp = 1;

        // Slots 0, 5, 19 to banks 1, 3, 0 with bank 3 stalled for 4 cycles.
        w = '0;
        w = put_slot(w, 0, 13'h1001, 11'h011);
        w = put_slot(w, 5, 13'h1003, 11'h155);
        w = put_slot(w, 19, 13'h1000, 11'h7FF);
        disp_ready = 4'b0111;
        send_inst(w);
        @(negedge clk);
        check("t2_first", {disp_valid, disp_slot, disp_minimizer}, {4'b0010, 5'd0, 11'h011});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_stall", {disp_valid, disp_slot, disp_minimizer}, {4'b1000, 5'd5, 11'h155});
            check("t2_stall_read", disp_read, w[511:200]);
        end
        disp_ready = 4'hF;
        @(negedge clk);
        check("t2_last", {disp_valid, disp_slot, disp_minimizer}, {4'b0001, 5'd19, 11'h7FF});
        check("t2_not_done", inst_done, 1'b0);
        @(negedge clk);
        check("t2_done", inst_done, 1'b1);
        exp_disp = 4;
        check("t2_count", disp_count, exp_disp);

        // Out-of-range bank only: dropped, no dispatch, immediate retire.
        w = '0;
        w = put_slot(w, 7, 13'h1010, 11'h123);
        send_inst(w);
        exp_drop = 1;
        @(negedge clk);
        check("t3_done", inst_done, 1'b1);
        check("t3_no_valid", disp_valid, 4'b0000);
        check("t3_drop", drop_count, exp_drop);
        check("t3_ready", inst_ready, 1'b1);
        check("t3_count", disp_count, exp_disp);

        // Slots 2 and 9 both to bank 1.
        w = '0;
        w = put_slot(w, 2, 13'h1001, 11'h0AA);
        w = put_slot(w, 9, 13'h1001, 11'h0BB);
        push_exp(1, 2, 11'h0AA);
`ifndef DISPATCH_DEDUP_EN
        push_exp(1, 9, 11'h0BB);
`endif
        send_inst(w);
        drain();

        // Reset in the middle of ISSUE with three slots pending.
        w = '0;
        w = put_slot(w, 1, 13'h1000, 11'h001);
        w = put_slot(w, 2, 13'h1001, 11'h002);
        w = put_slot(w, 3, 13'h1002, 11'h003);
        disp_ready = 4'h0;
        send_inst(w);
        @(negedge clk);
        check("t5_valid", disp_valid, 4'b0001);
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid", disp_valid, 4'b0000);
        check("t5_async_busy", busy, 1'b0);
        check("t5_ready_in_rst", inst_ready, 1'b0);
        @(negedge clk);
        rst        = 1'b0;
        disp_ready = 4'hF;
        exp_disp   = 0;
        exp_drop   = 0;
        @(negedge clk);
        check("t5_ready", inst_ready, 1'b1);
        check("t5_disp_count", disp_count, 0);
        check("t5_drop_count", drop_count, 0);
        check("t5_no_done", inst_done, 1'b0);
        @(negedge clk);
        check("t5_no_done2", inst_done, 1'b0);
        check("t5_valid_idle", disp_valid, 4'b0000);

        // Saturation: 63 instructions of 4 distinct-bank slots, then 2, then 3, then 1.
        for (int n = 0; n < 63; n++) begin
            l0 = 11'($urandom_range(0, 2047));
            l1 = 11'($urandom_range(0, 2047));
            l2 = 11'($urandom_range(0, 2047));
            l3 = 11'($urandom_range(0, 2047));
            w = '0;
            w = put_slot(w, 0, 13'h1000, l0);
            w = put_slot(w, 5, 13'h1001, l1);
            w = put_slot(w, 10, 13'h1002, l2);
            w = put_slot(w, 15, 13'h1003, l3);
            push_exp(0, 0, l0);
            push_exp(1, 5, l1);
            push_exp(2, 10, l2);
            push_exp(3, 15, l3);
            send_inst(w);
            drain();
        end
        check("t6_252", disp_count, 252);

        w = '0;
        w = put_slot(w, 4, 13'h1003, 11'h044);
        w = put_slot(w, 6, 13'h1002, 11'h066);
        push_exp(3, 4, 11'h044);
        push_exp(2, 6, 11'h066);
        send_inst(w);
        drain();
        check("t6_254", disp_count, MAX - 1);

        w = '0;
        w = put_slot(w, 11, 13'h1000, 11'h111);
        w = put_slot(w, 12, 13'h1001, 11'h122);
        w = put_slot(w, 18, 13'h1002, 11'h188);
        push_exp(0, 11, 11'h111);
        push_exp(1, 12, 11'h122);
        push_exp(2, 18, 11'h188);
        send_inst(w);
        drain();
        check("t6_sat", disp_count, MAX);

        w = '0;
        w = put_slot(w, 17, 13'h1001, 11'h177);
        push_exp(1, 17, 11'h177);
        send_inst(w);
        drain();
        check("t6_hold", disp_count, MAX);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
